// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter: FSM state encoding,
// parity sense selectors and line levels for the start and stop bits.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int   PARITY_EVEN = 0;
    localparam int   PARITY_ODD  = 1;

    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: XOR-reduce of the payload, inverted for odd sense.
module uart_tx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity_type,
    output logic                  parity
);

    assign parity = (^data) ^ parity_type;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter, one bit per clk: start, DATA_WIDTH bits LSB first, optional parity, stop.
// Optional tx_done stop-bit pulse is compiled in with UART_TX_DONE_PULSE_EN.
module uart_tx_top
    import uart_tx_pkg::*;
#(
    parameter int parity_type = PARITY_EVEN,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic                  parity_en,
    input  logic [DATA_WIDTH-1:0] P_Data,
    output logic                  TX_OUT,
    output logic                  busy,
    output tx_state_e             state_dbg
`ifdef UART_TX_DONE_PULSE_EN
    ,
    output logic                  tx_done
`endif
);

    localparam int              CNT_W     = $clog2(DATA_WIDTH);
    localparam logic            PAR_SENSE = (parity_type == PARITY_ODD);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
    logic                  par_en_q, par_en_n;
    logic                  par_bit_q, par_bit_n;
    logic                  par_calc;
    logic                  tx_out_n;
    logic                  busy_n;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data        (P_Data),
        .parity_type (PAR_SENSE),
        .parity      (par_calc)
    );

    // tx_out_n is the level the line takes after this edge, so TX_OUT stays a flop.
    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt_q;
        par_en_n  = par_en_q;
        par_bit_n = par_bit_q;
        tx_out_n  = STOP_BIT;
        case (state_q)
            IDLE, STOP: begin
                if (data_valid) begin
                    state_n   = START;
                    shift_n   = P_Data;
                    par_en_n  = parity_en;
                    par_bit_n = par_calc;
                    tx_out_n  = START_BIT;
                end else begin
                    state_n   = IDLE;
                end
            end
            START: begin
                state_n   = DATA;
                tx_out_n  = shift_q[0];
                shift_n   = shift_q >> 1;
                bit_cnt_n = '0;
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_n = '0;
                    if (par_en_q) begin
                        state_n  = PARITY;
                        tx_out_n = par_bit_q;
                    end else begin
                        state_n  = STOP;
                        tx_out_n = STOP_BIT;
                    end
                end else begin
                    bit_cnt_n = bit_cnt_q + CNT_W'(1);
                    tx_out_n  = shift_q[0];
                    shift_n   = shift_q >> 1;
                end
            end
            PARITY: begin
                state_n  = STOP;
                tx_out_n = STOP_BIT;
            end
            default: begin
                state_n  = IDLE;
                tx_out_n = STOP_BIT;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            TX_OUT    <= STOP_BIT;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            bit_cnt_q <= bit_cnt_n;
            par_en_q  <= par_en_n;
            par_bit_q <= par_bit_n;
            TX_OUT    <= tx_out_n;
            busy      <= busy_n;
        end
    end

`ifdef UART_TX_DONE_PULSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_done <= 1'b0;
        end else begin
            tx_done <= (state_n == STOP);
        end
    end
`endif

    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: even and odd parity instances share stimulus; each has a
// queue of expected {tx_done, busy, TX_OUT} samples checked one clock at a time.
module tb_uart_tx_top;
    import uart_tx_pkg::*;

    logic       clk;
    logic       rst;
    logic       data_valid;
    logic       parity_en;
    logic [7:0] P_Data;

    logic       tx_e, busy_e, done_e;
    logic       tx_o, busy_o, done_o;
    tx_state_e  state_dbg_e, state_dbg_o;

    logic [2:0] exp_e_q[$];
    logic [2:0] exp_o_q[$];

    int n_cmp;
    int n_err;

`ifdef UART_TX_DONE_PULSE_EN
    localparam logic DONE_EXP = 1'b1;
`else
    localparam logic DONE_EXP = 1'b0;
    assign done_e = 1'b0;
    assign done_o = 1'b0;
`endif

    uart_tx_top #(.parity_type(PARITY_EVEN), .DATA_WIDTH(8)) dut_even (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .parity_en  (parity_en),
        .P_Data     (P_Data),
        .TX_OUT     (tx_e),
        .busy       (busy_e),
        .state_dbg  (state_dbg_e)
`ifdef UART_TX_DONE_PULSE_EN
        ,
        .tx_done    (done_e)
`endif
    );

    uart_tx_top #(.parity_type(PARITY_ODD), .DATA_WIDTH(8)) dut_odd (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .parity_en  (parity_en),
        .P_Data     (P_Data),
        .TX_OUT     (tx_o),
        .busy       (busy_o),
        .state_dbg  (state_dbg_o)
`ifdef UART_TX_DONE_PULSE_EN
        ,
        .tx_done    (done_o)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line samples for one frame, built independently for each parity sense.
    task automatic push_frame(input logic [7:0] d, input logic pe);
        logic [2:0] fr[$];
        logic       par;
        for (int t = 0; t < 2; t++) begin
            fr.delete();
            par = (^d) ^ (t == 1);
            fr.push_back({1'b0, 1'b1, 1'b0});
            for (int i = 0; i < 8; i++) fr.push_back({1'b0, 1'b1, d[i]});
            if (pe) fr.push_back({1'b0, 1'b1, par});
            fr.push_back({DONE_EXP, 1'b1, 1'b1});
            foreach (fr[k]) begin
                if (t == 0) exp_e_q.push_back(fr[k]);
                else        exp_o_q.push_back(fr[k]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_e_q.size() > 0) check("even_line", {29'd0, done_e, busy_e, tx_e}, {29'd0, exp_e_q.pop_front()});
        if (exp_o_q.size() > 0) check("odd_line",  {29'd0, done_o, busy_o, tx_o}, {29'd0, exp_o_q.pop_front()});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            exp_e_q.push_back(3'b001);
            exp_o_q.push_back(3'b001);
            tick();
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe);
        data_valid = 1'b1;
        P_Data     = d;
        parity_en  = pe;
        push_frame(d, pe);
        tick();
        data_valid = 1'b0;
        repeat (pe ? 10 : 9) tick();
        idle(1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx_e"},    {31'd0, tx_e},   32'd1);
        check({tag, "_busy_e"},  {31'd0, busy_e}, 32'd0);
        check({tag, "_done_e"},  {31'd0, done_e}, 32'd0);
        check({tag, "_state_e"}, 32'(state_dbg_e), 32'(IDLE));
        check({tag, "_tx_o"},    {31'd0, tx_o},   32'd1);
        check({tag, "_busy_o"},  {31'd0, busy_o}, 32'd0);
        check({tag, "_state_o"}, 32'(state_dbg_o), 32'(IDLE));
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        data_valid = 1'b0;
        parity_en  = 1'b0;
        P_Data     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        idle(2);

        send(8'hCB, 1'b1);
        idle(1);
        send(8'hB2, 1'b1);
        send(8'h52, 1'b1);

        // back-to-back: data_valid held across the whole first frame
        data_valid = 1'b1;
        P_Data     = 8'hC6;
        parity_en  = 1'b1;
        push_frame(8'hC6, 1'b1);
        tick();
        P_Data = 8'h52;
        repeat (10) tick();
        push_frame(8'h52, 1'b1);
        tick();
        data_valid = 1'b0;
        repeat (10) tick();
        idle(2);

        send(8'hA3, 1'b0);
        idle(1);

        // mid-frame request with different data and parity_en must be ignored
        data_valid = 1'b1;
        P_Data     = 8'hCB;
        parity_en  = 1'b1;
        push_frame(8'hCB, 1'b1);
        tick();
        data_valid = 1'b0;
        repeat (3) tick();
        data_valid = 1'b1;
        P_Data     = 8'h0F;
        parity_en  = 1'b0;
        tick();
        data_valid = 1'b0;
        repeat (6) tick();
        idle(2);

        // asynchronous reset in the middle of the data bits
        data_valid = 1'b1;
        P_Data     = 8'hA5;
        parity_en  = 1'b1;
        push_frame(8'hA5, 1'b1);
        tick();
        data_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #2;
        exp_e_q.delete();
        exp_o_q.delete();
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("held_rst");
        rst = 1'b1;
        idle(2);
        send(8'h3C, 1'b1);
        idle(2);

        check("drain_even", exp_e_q.size(), 32'd0);
        check("drain_odd",  exp_o_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
